sd_spi_master: RTL and testbench

- Byte-oriented SPI mode-0 master that drives the SD-card SPI pins (spi_cs, spi_sclk, spi_mosi, spi_miso) of chip_top.
- Accepts bytes from a host-side valid/ready port, generates SCLK from a runtime divider, and manages chip-select.
- Returns each received byte on a one-cycle rx pulse.
- Sits between the SD/boot peripheral register block and the top-level SPI pads.

---
 rtl/sd_spi_pkg.sv | 14 +
 rtl/spi_half_timer.sv | 24 ++
 rtl/sd_spi_master.sv | 117 +++++++++++
 tb/tb_sd_spi_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and defaults for the SD-card SPI mode-0 master.
package sd_spi_pkg;
    localparam int DEF_DIV_W  = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_BIT_W  = $clog2(DEF_DATA_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } spi_state_t;
endpackage

// File: rtl/spi_half_timer.sv
// SCLK half-period timer: restarts at 0 on start, flags the last cycle when count reaches limit.
module spi_half_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] limit,
    output logic             expire
);
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign expire = (cnt == limit);
endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD-card pins, MSB first, runtime SCLK divider.
// state | meaning
// IDLE  | ready for a byte; CS released here unless cs_hold
// SETUP | CS just asserted, wait one half-period before first SCLK edge
// LOW   | SCLK low, MOSI holds current bit
// HIGH  | SCLK high, MISO captured on entry
// DONE  | one-cycle rx_valid, MOSI back to idle-high
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    input  logic              cs_hold,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_cs,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int BIT_W = $clog2(DATA_W);

    spi_state_t        state;
    logic [DIV_W-1:0]  div_q;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [BIT_W-1:0]  bit_cnt;
    logic              accept;
    logic              expire;
    logic              phase_end;
    logic              last_bit;

    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign phase_end = expire && ((state == SETUP) || (state == LOW) || (state == HIGH));
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));

    spi_half_timer #(.DIV_W(DIV_W)) u_half_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (accept || phase_end),
        .limit  (div_q),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            div_q    <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift <= tx_data;
                        div_q    <= div;
                        bit_cnt  <= '0;
                        spi_cs   <= 1'b0;
                        spi_mosi <= tx_data[DATA_W-1];
                        // A fresh CS assertion needs setup time; a held CS goes straight to clocking.
                        state    <= spi_cs ? SETUP : LOW;
                    end else if (!cs_hold) begin
                        spi_cs <= 1'b1;
                    end
                end
                SETUP: begin
                    if (expire) state <= LOW;
                end
                LOW: begin
                    if (expire) begin
                        state    <= HIGH;
                        spi_sclk <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], spi_miso};
                    end
                end
                HIGH: begin
                    if (expire) begin
                        spi_sclk <= 1'b0;
                        if (last_bit) begin
                            state    <= DONE;
                            rx_valid <= 1'b1;
                            rx_data  <= rx_shift;
                            spi_mosi <= 1'b1;
                        end else begin
                            state    <= LOW;
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            spi_mosi <= tx_shift[DATA_W-2];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!cs_hold) spi_cs <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: per-cycle timeline model plus literal latency/data checks.
module tb_sd_spi_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] div = 8'd0;
    logic       cs_hold = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready, rx_valid, busy, spi_cs, spi_sclk, spi_mosi, spi_miso;
    logic [7:0] rx_data;
    logic       miso_loop = 1'b1;
    logic       miso_val = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;

    assign spi_miso = miso_loop ? spi_mosi : miso_val;

    sd_spi_master #(.DIV_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .div      (div),
        .cs_hold  (cs_hold),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Model: a byte accepted in cycle T occupies an optional setup half-period,
    // then 16 alternating low/high half-periods, then one done cycle.
    logic       m_active = 1'b0;
    logic       m_cs = 1'b1;
    int         m_t = 0, m_setup = 0, m_h = 1;
    logic [7:0] m_tx = 8'd0, m_rx = 8'd0, m_rxd = 8'd0;

    int         rise_cnt = 0, hi_run = 0, last_hi = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] mosi_seq = 8'd0;

    always @(negedge clk) begin
        int j, ph;
        logic e_sclk, e_mosi, e_rxv;
        logic [7:0] e_rxd;
        bit done_now;
        if (rst) begin
            m_active = 1'b0;
            m_cs = 1'b1;
            m_rxd = 8'd0;
            chk("rst_cs", spi_cs, 1);
            chk("rst_sclk", spi_sclk, 0);
            chk("rst_mosi", spi_mosi, 1);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tx_ready", tx_ready, 1);
        end else begin
            e_sclk = 1'b0; e_mosi = 1'b1; e_rxv = 1'b0; e_rxd = m_rxd; done_now = 1'b0; j = 0; ph = 0;
            if (m_active) begin
                j = cyc - m_t - 1 - m_setup;
                if (j < 0) begin
                    e_mosi = m_tx[7];
                end else if (j < 16 * m_h) begin
                    ph = j / m_h;
                    e_sclk = ((ph % 2) == 1);
                    e_mosi = m_tx[7 - ph / 2];
                end else begin
                    e_rxv = 1'b1;
                    e_rxd = m_rx;
                    done_now = 1'b1;
                end
            end
            chk("tx_ready", tx_ready, !m_active);
            chk("busy", busy, m_active);
            chk("spi_cs", spi_cs, m_cs);
            chk("spi_sclk", spi_sclk, e_sclk);
            chk("spi_mosi", spi_mosi, e_mosi);
            chk("rx_valid", rx_valid, e_rxv);
            chk("rx_data", rx_data, e_rxd);
            if (done_now) begin
                m_active = 1'b0;
                m_rxd = m_rx;
                if (!cs_hold) m_cs = 1'b1;
            end else if (!m_active) begin
                if (tx_valid) begin
                    m_active = 1'b1;
                    m_t = cyc;
                    m_h = int'(div) + 1;
                    m_setup = m_cs ? m_h : 0;
                    m_tx = tx_data;
                    m_rx = miso_loop ? tx_data : {8{miso_val}};
                    m_cs = 1'b0;
                end else if (!cs_hold) begin
                    m_cs = 1'b1;
                end
            end
        end
        if (spi_sclk && !prev_sclk) begin
            rise_cnt++;
            mosi_seq = {mosi_seq[6:0], spi_mosi};
        end
        if (spi_sclk) hi_run++;
        else if (hi_run > 0) begin
            last_hi = hi_run;
            hi_run = 0;
        end
        prev_sclk = spi_sclk;
    end

    task automatic send(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        tx_data = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                t_acc = cyc;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(output int lat, output logic [7:0] d);
        bit ok;
        ok = 1'b0;
        lat = -1;
        d = 8'hxx;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                lat = cyc - t_acc;
                d = rx_data;
                break;
            end
        end
        chk("rx_timeout", 32'(ok), 1);
    endtask

    initial begin
        int lat;
        logic [7:0] d;
        bit bad;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_cs", spi_cs, 1);
        chk("post_rst_mosi", spi_mosi, 1);

        // loopback, div=0, CS released after the byte
        rise_cnt = 0;
        send(8'hA5);
        wait_rx(lat, d);
        chk("a5_latency", lat, 18);
        chk("a5_data", d, 8'hA5);
        @(negedge clk);
        chk("a5_cs_release", spi_cs, 1);
        #1 chk("a5_rises", rise_cnt, 8);

        // div=3, MISO stuck low, all-ones byte
        @(posedge clk); #1;
        miso_loop = 1'b0; miso_val = 1'b0; div = 8'd3; rise_cnt = 0;
        send(8'hFF);
        wait_rx(lat, d);
        chk("ff_latency", lat, 69);
        chk("ff_data", d, 8'h00);
        @(posedge clk); #1;
        chk("ff_rises", rise_cnt, 8);
        chk("ff_mosi_seq", mosi_seq, 8'hFF);
        chk("ff_high_len", last_hi, 4);
        miso_loop = 1'b1; div = 8'd0;

        // CS held across back-to-back bytes
        cs_hold = 1'b1;
        send(8'h12);
        wait_rx(lat, d);
        chk("b1_latency", lat, 18);
        chk("b1_data", d, 8'h12);
        send(8'h34);
        wait_rx(lat, d);
        chk("b2_latency", lat, 17);
        chk("b2_data", d, 8'h34);
        @(posedge clk); #1;
        cs_hold = 1'b0;
        @(negedge clk);
        chk("hold_cs_still_low", spi_cs, 0);
        @(negedge clk);
        chk("hold_cs_released", spi_cs, 1);

        // divider change mid-byte only affects the next byte
        send(8'h3C);
        div = 8'd7;
        wait_rx(lat, d);
        chk("div_old_latency", lat, 18);
        chk("div_old_data", d, 8'h3C);
        send(8'hC3);
        wait_rx(lat, d);
        chk("div_new_latency", lat, 137);
        chk("div_new_data", d, 8'hC3);
        @(posedge clk); #1;
        div = 8'd0;

        // tx_valid held while busy, tx_data scrambled after the handshake
        @(posedge clk); #1;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        bad = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                t_acc = cyc;
                bad = 1'b0;
                break;
            end
        end
        chk("held_accept", 32'(bad), 0);
        lat = -1;
        d = 8'h00;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            tx_data = 8'($urandom);
            @(negedge clk);
            if (rx_valid) begin
                lat = cyc - t_acc;
                d = rx_data;
                break;
            end
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("held_latency", lat, 18);
        chk("held_data", d, 8'h5A);

        // reset five cycles into a byte
        repeat (2) @(posedge clk); #1;
        send(8'h96);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cs", spi_cs, 1);
        chk("mid_rst_sclk", spi_sclk, 0);
        chk("mid_rst_mosi", spi_mosi, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rx_valid) bad = 1'b1;
        end
        chk("mid_rst_no_rx", 32'(bad), 0);
        chk("mid_rst_ready", tx_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required finish before that", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
